// File: rtl/rblwe_encrypt_if.sv
// Interface bundling the operand-load, control and ciphertext-stream signals
// of the RBLWE encryption stage.
//   master : drives in_valid, a_in, p_in, e1_in, e2_in, e3_in, m_in, start;
//            observes busy, out_valid, c1_out, c2_out, done
//   slave  : the encryptor side (mirror of master)
// Optional macro RBLWE_SIGNED_ERR_EN widens e2_in/e3_in to 2-bit signed codes.
interface rblwe_encrypt_if #(
  parameter int Q_BITS = 8
);
`ifdef RBLWE_SIGNED_ERR_EN
  localparam int ERR_W = 2;
`else
  localparam int ERR_W = 1;
`endif

  logic              in_valid;
  logic [Q_BITS-1:0] a_in;
  logic [Q_BITS-1:0] p_in;
  logic              e1_in;
  logic [ERR_W-1:0]  e2_in;
  logic [ERR_W-1:0]  e3_in;
  logic              m_in;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic [Q_BITS-1:0] c1_out;
  logic [Q_BITS-1:0] c2_out;
  logic              done;

  modport master (
    output in_valid, a_in, p_in, e1_in, e2_in, e3_in, m_in, start,
    input  busy, out_valid, c1_out, c2_out, done
  );

  modport slave (
    input  in_valid, a_in, p_in, e1_in, e2_in, e3_in, m_in, start,
    output busy, out_valid, c1_out, c2_out, done
  );
endinterface

// File: rtl/rblwe_encrypt.sv
// RBLWE encryption stage. Loads a, p, e1, e2, e3 and m one coefficient per
// in_valid beat, then on start computes
//   c1 = a*e1 + e2,  c2 = p*e1 + e3 + ENC_OFFSET*m   in Z_2^Q_BITS[x]/(x^N+1)
// and streams c1/c2 one coefficient per cycle (byte 0 on the first out_valid).
// Ports: clk, reset (async, active-high), bus (rblwe_encrypt_if.slave).
// Optional macro RBLWE_SIGNED_ERR_EN: e2/e3 become 2-bit codes
//   00=0, 01=+1, 11=-1, 10=0.
module rblwe_encrypt #(
  parameter int N          = 256,
  parameter int Q_BITS     = 8,
  parameter int ENC_OFFSET = 128
) (
  input logic            clk,
  input logic            reset,
  rblwe_encrypt_if.slave bus
);
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(N - 1);
  localparam logic [Q_BITS-1:0] OFFSET_Q = Q_BITS'(ENC_OFFSET);
`ifdef RBLWE_SIGNED_ERR_EN
  localparam int ERR_W = 2;
`else
  localparam int ERR_W = 1;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, READY, MULT, ADD_ERR, STREAM, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  load_cnt_reg, mul_cnt_reg, str_cnt_reg;
  logic              busy_reg, out_valid_reg, done_reg;
  logic [Q_BITS-1:0] c1_reg, c2_reg;

  // operand storage
  logic [Q_BITS-1:0] a_mem [N];
  logic [Q_BITS-1:0] p_mem [N];
  logic [N-1:0]      e1_mem;
  logic [N-1:0]      m_mem;
  logic [ERR_W-1:0]  e2_mem [N];
  logic [ERR_W-1:0]  e3_mem [N];

  // rotation registers and accumulators
  logic [Q_BITS-1:0] ra_reg [N];
  logic [Q_BITS-1:0] rp_reg [N];
  logic [Q_BITS-1:0] acc1_reg [N];
  logic [Q_BITS-1:0] acc2_reg [N];

  // per-lane next values
  logic [Q_BITS-1:0] mac1 [N];
  logic [Q_BITS-1:0] mac2 [N];
  logic [Q_BITS-1:0] rot_a [N];
  logic [Q_BITS-1:0] rot_p [N];
  logic [Q_BITS-1:0] fin1 [N];
  logic [Q_BITS-1:0] fin2 [N];
  logic              e1_cur;

  function automatic logic [Q_BITS-1:0] err_val(input logic [ERR_W-1:0] e);
`ifdef RBLWE_SIGNED_ERR_EN
    case (e)
      2'b01:   return Q_BITS'(1);
      2'b11:   return '1;          // -1 mod 2^Q_BITS
      default: return '0;          // 2'b10 is an unused code, treated as 0
    endcase
`else
    return Q_BITS'(e);
`endif
  endfunction

  assign e1_cur = e1_mem[mul_cnt_reg];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign mac1[gi] = acc1_reg[gi] + (e1_cur ? ra_reg[gi] : '0);
      assign mac2[gi] = acc2_reg[gi] + (e1_cur ? rp_reg[gi] : '0);
      if (gi == 0) begin : g_wrap
        // multiplying by x pushes the top coefficient past x^N = -1;
        // subtraction mod 2^Q_BITS maps 0 to 0 naturally
        assign rot_a[gi] = Q_BITS'(0) - ra_reg[N-1];
        assign rot_p[gi] = Q_BITS'(0) - rp_reg[N-1];
      end else begin : g_shift
        assign rot_a[gi] = ra_reg[gi-1];
        assign rot_p[gi] = rp_reg[gi-1];
      end
      assign fin1[gi] = acc1_reg[gi] + err_val(e2_mem[gi]);
      assign fin2[gi] = acc2_reg[gi] + err_val(e3_mem[gi]) + (m_mem[gi] ? OFFSET_Q : '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      load_cnt_reg  <= '0;
      mul_cnt_reg   <= '0;
      str_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      c1_reg        <= '0;
      c2_reg        <= '0;
      e1_mem        <= '0;
      m_mem         <= '0;
      for (int j = 0; j < N; j++) begin
        a_mem[j]    <= '0;
        p_mem[j]    <= '0;
        e2_mem[j]   <= '0;
        e3_mem[j]   <= '0;
        ra_reg[j]   <= '0;
        rp_reg[j]   <= '0;
        acc1_reg[j] <= '0;
        acc2_reg[j] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // load_cnt is always 0 in IDLE, so the first beat lands at k=0
        IDLE, LOAD: begin
          if (bus.in_valid) begin
            a_mem[load_cnt_reg]  <= bus.a_in;
            p_mem[load_cnt_reg]  <= bus.p_in;
            e1_mem[load_cnt_reg] <= bus.e1_in;
            e2_mem[load_cnt_reg] <= bus.e2_in;
            e3_mem[load_cnt_reg] <= bus.e3_in;
            m_mem[load_cnt_reg]  <= bus.m_in;
            if (load_cnt_reg == LAST) begin
              load_cnt_reg <= '0;
              state_reg    <= READY;
              busy_reg     <= 1'b0;
            end else begin
              load_cnt_reg <= load_cnt_reg + 1'b1;
              state_reg    <= LOAD;
              busy_reg     <= 1'b1;
            end
          end
        end
        READY: begin
          if (bus.start) begin
            for (int j = 0; j < N; j++) begin
              ra_reg[j]   <= a_mem[j];
              rp_reg[j]   <= p_mem[j];
              acc1_reg[j] <= '0;
              acc2_reg[j] <= '0;
            end
            mul_cnt_reg <= '0;
            state_reg   <= MULT;
            busy_reg    <= 1'b1;
          end
        end
        // step i: acc += e1[i] * (a * x^i), then advance r to a * x^(i+1)
        MULT: begin
          for (int j = 0; j < N; j++) begin
            acc1_reg[j] <= mac1[j];
            acc2_reg[j] <= mac2[j];
            ra_reg[j]   <= rot_a[j];
            rp_reg[j]   <= rot_p[j];
          end
          if (mul_cnt_reg == LAST) begin
            mul_cnt_reg <= '0;
            state_reg   <= ADD_ERR;
          end else begin
            mul_cnt_reg <= mul_cnt_reg + 1'b1;
          end
        end
        // coefficient 0 goes straight to the output registers so that
        // byte 0 is present in the first out_valid cycle
        ADD_ERR: begin
          for (int j = 0; j < N; j++) begin
            acc1_reg[j] <= fin1[j];
            acc2_reg[j] <= fin2[j];
          end
          c1_reg        <= fin1[0];
          c2_reg        <= fin2[0];
          out_valid_reg <= 1'b1;
          str_cnt_reg   <= '0;
          state_reg     <= STREAM;
        end
        STREAM: begin
          if (str_cnt_reg == LAST) begin
            str_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            c1_reg        <= '0;
            c2_reg        <= '0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            str_cnt_reg <= str_cnt_reg + 1'b1;
            c1_reg      <= acc1_reg[str_cnt_reg + 1'b1];
            c2_reg      <= acc2_reg[str_cnt_reg + 1'b1];
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.c1_out    = c1_reg;
  assign bus.c2_out    = c2_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_rblwe_encrypt.sv
// Directed testbench for rblwe_encrypt: table of point vectors plus full-stream
// comparisons, latency checks, READY corner cases and a mid-stream reset.
`timescale 1ns/1ps
module tb_rblwe_encrypt;
  localparam int N = 256;
`ifdef RBLWE_SIGNED_ERR_EN
  localparam int ERR_W = 2;
`else
  localparam int ERR_W = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rblwe_encrypt_if #(.Q_BITS(8)) bus ();
  rblwe_encrypt #(.N(N), .Q_BITS(8), .ENC_OFFSET(128)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int       scen;
    int       idx;
    bit [7:0] c1;
    bit [7:0] c2;
  } vec_t;
  vec_t tbl[12];

  bit [7:0]       va[N], vp[N];
  bit             ve1[N], vm[N];
  bit [ERR_W-1:0] ve2[N], ve3[N];
  bit [7:0]       exp_c1[N], exp_c2[N], got_c1[N], got_c2[N];
  int n_vec = 0, n_bad = 0;
  int first_ov, n_ov, done_at, n_done;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic bit [7:0] err(input bit [ERR_W-1:0] e);
`ifdef RBLWE_SIGNED_ERR_EN
    if (e == 2'b01) return 8'h01;
    if (e == 2'b11) return 8'hFF;
    return 8'h00;
`else
    return {7'b0, e};
`endif
  endfunction

  task automatic clear_ops();
    for (int k = 0; k < N; k++) begin
      va[k] = 0; vp[k] = 0; ve1[k] = 0; ve2[k] = 0; ve3[k] = 0; vm[k] = 0;
      exp_c1[k] = 0; exp_c2[k] = 0;
    end
  endtask

  // loads all operands; optional idle gaps; a stray start mid-load must be ignored
  task automatic load_ops(input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps && (k % 41 == 7)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.a_in = va[k]; bus.p_in = vp[k]; bus.e1_in = ve1[k];
      bus.e2_in = ve2[k]; bus.e3_in = ve3[k]; bus.m_in = vm[k];
      bus.start = (k == 10);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k == 128) check("busy during load", bus.busy, 1);
    end
    bus.in_valid = 1'b0;
    check("busy in ready", bus.busy, 0);
  endtask

  // junk=1: stray in_valid beat in READY, then in_valid together with start
  task automatic run_enc(input bit junk);
    if (junk) begin
      bus.in_valid = 1'b1; bus.a_in = 8'hFF; bus.p_in = 8'hFF; bus.e1_in = 1'b1;
      @(posedge clk); #1;
      check("ready ignores in_valid", bus.busy, 0);
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    first_ov = -1; n_ov = 0; done_at = -1; n_done = 0;
    for (int s = 1; s <= 2*N + 8; s++) begin
      if (bus.out_valid) begin
        if (first_ov < 0) first_ov = s;
        if (n_ov < N) begin
          got_c1[n_ov] = bus.c1_out;
          got_c2[n_ov] = bus.c2_out;
        end
        n_ov++;
      end
      if (bus.done) begin
        n_done++;
        done_at = s;
      end
      @(posedge clk); #1;
    end
    check("first out_valid cycle", first_ov, N + 2);
    check("out_valid beat count", n_ov, N);
    check("done cycle", done_at, 2*N + 2);
    check("done pulse count", n_done, 1);
  endtask

  task automatic cmp_stream(input string name, input bit sel_c1);
    int bad, first;
    bit [7:0] g, e, g0, e0;
    bad = 0; first = -1; g0 = 0; e0 = 0;
    for (int j = 0; j < N; j++) begin
      g = sel_c1 ? got_c1[j] : got_c2[j];
      e = sel_c1 ? exp_c1[j] : exp_c2[j];
      if (g != e) begin
        if (first < 0) begin first = j; g0 = g; e0 = e; end
        bad++;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: %0d wrong coefficients, first [%0d] got 0x%02h expected 0x%02h",
               name, bad, first, g0, e0);
    end
  endtask

  task automatic check_table(input int scen);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].scen == scen) begin
        check($sformatf("s%0d c1[%0d]", scen, tbl[i].idx), got_c1[tbl[i].idx], tbl[i].c1);
        check($sformatf("s%0d c2[%0d]", scen, tbl[i].idx), got_c2[tbl[i].idx], tbl[i].c2);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0] pat;
    int beats, mhat_bad, cnt;
    bit [7:0] dec;

    tbl[0]  = '{1, 0,   8'h00, 8'h80};
    tbl[1]  = '{1, 1,   8'h00, 8'h00};
    tbl[2]  = '{1, 2,   8'h00, 8'h80};
    tbl[3]  = '{1, 7,   8'h00, 8'h80};
    tbl[4]  = '{1, 255, 8'h00, 8'h80};
    tbl[5]  = '{2, 0,   8'h00, 8'h00};
    tbl[6]  = '{2, 3,   8'h04, 8'h00};
    tbl[7]  = '{2, 200, 8'hC8, 8'h00};
    tbl[8]  = '{2, 255, 8'hFF, 8'h00};
    tbl[9]  = '{3, 0,   8'hFB, 8'hFB};
    tbl[10] = '{3, 1,   8'h00, 8'h00};
    tbl[11] = '{3, 255, 8'h00, 8'h00};

    reset = 1'b1;
    bus.in_valid = 0; bus.a_in = 0; bus.p_in = 0; bus.e1_in = 0;
    bus.e2_in = 0; bus.e3_in = 0; bus.m_in = 0; bus.start = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset done", bus.done, 0);
    check("reset busy", bus.busy, 0);
    check("reset c1_out", bus.c1_out, 0);
    check("reset c2_out", bus.c2_out, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // S1: zero keys, m = 0xA5 in every byte
    clear_ops();
    pat = 8'hA5;
    for (int k = 0; k < N; k++) begin
      vm[k] = pat[k % 8];
      exp_c2[k] = vm[k] ? 8'h80 : 8'h00;
    end
    load_ops(1'b1);
    run_enc(1'b0);
    cmp_stream("s1 c1 stream", 1'b1);
    cmp_stream("s1 c2 stream", 1'b0);
    check_table(1);

    // S2: a[j]=j, e1=1, e2[3]=1; start with simultaneous in_valid
    clear_ops();
    for (int k = 0; k < N; k++) begin
      va[k] = k[7:0];
      exp_c1[k] = k[7:0];
    end
    ve1[0] = 1; ve2[3] = 1; exp_c1[3] = 8'h04;
    load_ops(1'b0);
    run_enc(1'b1);
    cmp_stream("s2 c1 stream", 1'b1);
    cmp_stream("s2 c2 stream", 1'b0);
    check_table(2);

    // S4: a=p=0, random e/m; c2 must round back to m
    clear_ops();
    for (int k = 0; k < N; k++) begin
      ve1[k] = 1'($urandom_range(0, 1));
      ve2[k] = ERR_W'($urandom_range(0, (1 << ERR_W) - 1));
      ve3[k] = ERR_W'($urandom_range(0, (1 << ERR_W) - 1));
      vm[k]  = 1'($urandom_range(0, 1));
      exp_c1[k] = err(ve2[k]);
      exp_c2[k] = err(ve3[k]) + (vm[k] ? 8'h80 : 8'h00);
    end
    load_ops(1'b1);
    run_enc(1'b0);
    cmp_stream("s4 c1 stream", 1'b1);
    cmp_stream("s4 c2 stream", 1'b0);
    mhat_bad = 0;
    for (int j = 0; j < N; j++) begin
      dec = got_c2[j] + 8'h40;
      if (dec[7] != vm[j]) mhat_bad++;
    end
    check("s4 decoded message bit errors", mhat_bad, 0);

    // S5: schoolbook negacyclic product as reference
    clear_ops();
    for (int k = 0; k < N; k++) begin
      va[k]  = (k % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      vp[k]  = 8'($urandom_range(0, 255));
      ve1[k] = ($urandom_range(0, 7) == 0);
      ve2[k] = ERR_W'($urandom_range(0, (1 << ERR_W) - 1));
      ve3[k] = ERR_W'($urandom_range(0, (1 << ERR_W) - 1));
      vm[k]  = 1'($urandom_range(0, 1));
    end
    ve1[N-1] = 1;
    for (int j = 0; j < N; j++) begin
      exp_c1[j] = err(ve2[j]);
      exp_c2[j] = err(ve3[j]) + (vm[j] ? 8'h80 : 8'h00);
    end
    for (int i = 0; i < N; i++) begin
      if (ve1[i]) begin
        for (int j = 0; j < N; j++) begin
          if (i + j < N) begin
            exp_c1[i+j] += va[j];
            exp_c2[i+j] += vp[j];
          end else begin
            exp_c1[i+j-N] -= va[j];
            exp_c2[i+j-N] -= vp[j];
          end
        end
      end
    end
    load_ops(1'b0);
    run_enc(1'b0);
    cmp_stream("s5 c1 stream", 1'b1);
    cmp_stream("s5 c2 stream", 1'b0);

    // S6: reset at stream beat 100, then fresh load of the wrap case (S3)
    clear_ops();
    for (int k = 0; k < N; k++) va[k] = k[7:0];
    ve1[0] = 1;
    load_ops(1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    beats = 0;
    for (int s = 1; s <= 2*N + 8; s++) begin
      if (bus.out_valid) beats++;
      if (beats == 101) break;
      @(posedge clk); #1;
    end
    check("reached stream beat 100", beats, 101);
    reset = 1'b1;
    #1;
    check("async out_valid drop", bus.out_valid, 0);
    check("busy cleared by reset", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int s = 0; s < N + 8; s++) begin
      if (bus.done || bus.out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("no activity after abort", cnt, 0);

    clear_ops();
    va[N-1] = 8'h05; vp[N-1] = 8'h05; ve1[1] = 1;
    exp_c1[0] = 8'hFB; exp_c2[0] = 8'hFB;
    load_ops(1'b1);
    run_enc(1'b0);
    cmp_stream("s3 c1 stream", 1'b1);
    cmp_stream("s3 c2 stream", 1'b0);
    check_table(3);

`ifdef RBLWE_SIGNED_ERR_EN
    // S7: signed error codes
    clear_ops();
    ve2[0] = 2'b11; ve2[1] = 2'b01; ve3[5] = 2'b10; vm[5] = 1; ve3[6] = 2'b11;
    exp_c1[0] = 8'hFF; exp_c1[1] = 8'h01; exp_c2[5] = 8'h80; exp_c2[6] = 8'hFF;
    load_ops(1'b0);
    run_enc(1'b0);
    cmp_stream("s7 c1 stream", 1'b1);
    cmp_stream("s7 c2 stream", 1'b0);
    check("s7 c1[0]", got_c1[0], 8'hFF);
    check("s7 c2[5]", got_c2[5], 8'h80);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
